// File: rtl/cva6_wrapper_pkg.sv
// cva6_wrapper_pkg: SoC-level constants for the CVA6 wrapper.
// Holds the CLINT window, its internal register offsets, the bus response
// payload and a byte-enable merge helper shared by the CLINT register file.
package cva6_wrapper_pkg;

  localparam logic [63:0] CLINTBase   = 64'h0000_0000_0200_0000;
  localparam logic [63:0] CLINTLength = 64'h0000_0000_000C_0000;

  localparam logic [31:0] ClintMsipOffset     = 32'h0000_0000;
  localparam logic [31:0] ClintMtimecmpOffset = 32'h0000_4000;
  localparam logic [31:0] ClintMtimeOffset    = 32'h0000_BFF8;
  localparam int unsigned ClintMaxHarts       = 64;

  // Registered response payload of the CLINT register port.
  typedef struct packed {
    logic        err;
    logic [63:0] rdata;
  } clint_rsp_t;

  // Replace the bytes of old_val selected by be with the matching bytes of new_val.
  function automatic logic [63:0] be_merge(input logic [63:0] old_val,
                                           input logic [63:0] new_val,
                                           input logic [7:0]  be);
    logic [63:0] res;
    res = old_val;
    for (int unsigned b = 0; b < 8; b++) begin
      if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/cva6_wrapper_clint_rtc_sync.sv
// cva6_wrapper_clint_rtc_sync: brings the asynchronous RTC input into the
// clk_i domain and flags each rising edge.
// Ports: clk_i/rst_ni clock and async active-low reset; rtc_i raw RTC input;
//        tick one-cycle pulse per synchronized rising edge of rtc_i.
module cva6_wrapper_clint_rtc_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic rtc_i,
  output logic tick
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // Two-flop synchronizer followed by a previous-value flop for edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= rtc_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign tick = sync2_q & ~prev_q;

endmodule

// File: rtl/cva6_wrapper_clint.sv
// cva6_wrapper_clint: core-local interruptor (msip, mtimecmp, mtime).
// Ports: clk_i/rst_ni clock and async active-low reset; rtc_i RTC tick input;
//        req_i/we_i/addr_i/wdata_i/be_i register bus request;
//        gnt_o (always 1), rvalid_o/rdata_o/err_o registered response;
//        timer_irq_o/ipi_o per-hart machine timer and software interrupts.
module cva6_wrapper_clint
  import cva6_wrapper_pkg::*;
#(
  parameter int unsigned NrHarts   = 1,
  parameter int unsigned AddrWidth = 20
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rtc_i,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [63:0]          wdata_i,
  input  logic [7:0]           be_i,
  output logic                 gnt_o,
  output logic                 rvalid_o,
  output logic [63:0]          rdata_o,
  output logic                 err_o,
  output logic [NrHarts-1:0]   timer_irq_o,
  output logic [NrHarts-1:0]   ipi_o
);

  // Harts beyond the architectural maximum are never decoded.
  localparam int unsigned HartLimit   = (NrHarts < ClintMaxHarts) ? NrHarts : ClintMaxHarts;
  localparam int unsigned MsipWords   = (HartLimit + 1) / 2;
  localparam logic [31:0] MsipWord    = ClintMsipOffset >> 3;
  localparam logic [31:0] CmpWord     = ClintMtimecmpOffset >> 3;
  localparam logic [31:0] MtimeWord   = ClintMtimeOffset >> 3;

  logic              tick;
  logic [63:0]       mtime_q,  mtime_d;
  logic [63:0]       cmp_q [NrHarts];
  logic [63:0]       cmp_d [NrHarts];
  logic [NrHarts-1:0] msip_q, msip_d;
  logic [NrHarts-1:0] irq_q,  irq_d;
  logic              rvalid_q;
  clint_rsp_t        rsp_q, rsp_d;

  logic [31:0] word;
  logic [31:0] msip_idx;
  logic [31:0] cmp_idx;
  logic        in_window;
  logic        msip_hit;
  logic        cmp_hit;
  logic        mtime_hit;
  logic        hit;
  logic [2:0]  unused_addr_lsb;

  assign unused_addr_lsb = addr_i[2:0];

  cva6_wrapper_clint_rtc_sync i_rtc_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .rtc_i  (rtc_i),
    .tick   (tick)
  );

  // Address decode on 8-byte word granularity.
  always_comb begin
    word      = 32'(addr_i[AddrWidth-1:3]);
    in_window = 64'(addr_i) < CLINTLength;
    msip_idx  = word - MsipWord;
    cmp_idx   = word - CmpWord;
    msip_hit  = in_window && (word >= MsipWord) && (msip_idx < 32'(MsipWords));
    cmp_hit   = in_window && (word >= CmpWord) && (cmp_idx < 32'(HartLimit));
    mtime_hit = in_window && (word == MtimeWord);
    hit       = msip_hit || cmp_hit || mtime_hit;
  end

  // Register file next state, read mux and timer comparators.
  always_comb begin
    mtime_d = mtime_q + 64'(tick);
    cmp_d   = cmp_q;
    msip_d  = msip_q;
    rsp_d   = '0;
    irq_d   = '0;

    if (req_i && hit) begin
      if (we_i) begin
        // A bus write beats a coincident tick only in the enabled bytes.
        if (mtime_hit) mtime_d = be_merge(mtime_d, wdata_i, be_i);
        for (int unsigned h = 0; h < NrHarts; h++) begin
          if (cmp_hit && cmp_idx == 32'(h)) cmp_d[h] = be_merge(cmp_q[h], wdata_i, be_i);
          if (msip_hit && msip_idx == 32'(h / 2)) begin
            if (h % 2 == 0) begin
              if (be_i[0]) msip_d[h] = wdata_i[0];
            end else begin
              if (be_i[4]) msip_d[h] = wdata_i[32];
            end
          end
        end
      end else begin
        if (mtime_hit) rsp_d.rdata = mtime_q;
        for (int unsigned h = 0; h < NrHarts; h++) begin
          if (cmp_hit && cmp_idx == 32'(h)) rsp_d.rdata = cmp_q[h];
          if (msip_hit && msip_idx == 32'(h / 2)) begin
            if (h % 2 == 0) rsp_d.rdata[0]  = msip_q[h];
            else            rsp_d.rdata[32] = msip_q[h];
          end
        end
      end
    end
    rsp_d.err = req_i && !hit;

    for (int unsigned h = 0; h < NrHarts; h++) begin
      irq_d[h] = mtime_q >= cmp_q[h];
    end
  end

  // State and response registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mtime_q  <= '0;
      msip_q   <= '0;
      irq_q    <= '0;
      rvalid_q <= 1'b0;
      rsp_q    <= '0;
      for (int unsigned h = 0; h < NrHarts; h++) cmp_q[h] <= '1;
    end else begin
      mtime_q  <= mtime_d;
      msip_q   <= msip_d;
      irq_q    <= irq_d;
      rvalid_q <= req_i;
      rsp_q    <= rsp_d;
      for (int unsigned h = 0; h < NrHarts; h++) cmp_q[h] <= cmp_d[h];
    end
  end

  assign gnt_o       = 1'b1;
  assign rvalid_o    = rvalid_q;
  assign rdata_o     = rsp_q.rdata;
  assign err_o       = rsp_q.err;
  assign timer_irq_o = irq_q;
  assign ipi_o       = msip_q;

endmodule

// File: tb/tb_cva6_wrapper_clint.sv
// tb_cva6_wrapper_clint: directed and randomized bench for the CLINT with a
// two-hart configuration, checked against a behavioural register-map model.
module tb_cva6_wrapper_clint;

  localparam int unsigned NH = 2;
  localparam int unsigned AW = 20;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rtc;
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [63:0]   wdata;
  logic [7:0]    be;
  logic          gnt;
  logic          rvalid;
  logic [63:0]   rdata;
  logic          err;
  logic [NH-1:0] timer_irq;
  logic [NH-1:0] ipi;

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model state.
  logic [63:0]   m_mtime;
  logic [63:0]   m_cmp [NH];
  logic [NH-1:0] m_msip;

  always #5 clk = ~clk;

  cva6_wrapper_clint #(.NrHarts(NH), .AddrWidth(AW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .rtc_i       (rtc),
    .req_i       (req),
    .we_i        (we),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .be_i        (be),
    .gnt_o       (gnt),
    .rvalid_o    (rvalid),
    .rdata_o     (rdata),
    .err_o       (err),
    .timer_irq_o (timer_irq),
    .ipi_o       (ipi)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_mtime = 64'd0;
    m_msip  = '0;
    for (int h = 0; h < NH; h++) m_cmp[h] = '1;
  endfunction

  function automatic logic [63:0] merge_bytes(input logic [63:0] o, input logic [63:0] n,
                                              input logic [7:0] b);
    logic [63:0] r;
    r = o;
    for (int i = 0; i < 8; i++) if (b[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  function automatic logic [NH-1:0] model_irq();
    logic [NH-1:0] r;
    for (int h = 0; h < NH; h++) r[h] = (m_mtime >= m_cmp[h]);
    return r;
  endfunction

  // Applies one access to the model; returns the expected response.
  function automatic void model_access(input logic a_we, input logic [AW-1:0] a_addr,
                                       input logic [63:0] a_wd, input logic [7:0] a_be,
                                       output logic [63:0] rd, output logic e);
    int unsigned off;
    int unsigned k;
    off = 32'(a_addr) & ~32'h7;
    rd  = 64'd0;
    e   = 1'b0;
    if (off < 8 * ((NH + 1) / 2)) begin
      k = off / 8;
      if (a_we) begin
        if (a_be[0]) m_msip[2*k] = a_wd[0];
        if ((2*k + 1 < NH) && a_be[4]) m_msip[2*k+1] = a_wd[32];
      end else begin
        rd[0] = m_msip[2*k];
        if (2*k + 1 < NH) rd[32] = m_msip[2*k+1];
      end
    end else if (off >= 32'h4000 && off < 32'h4000 + 8 * NH) begin
      k = (off - 32'h4000) / 8;
      if (a_we) m_cmp[k] = merge_bytes(m_cmp[k], a_wd, a_be);
      else      rd = m_cmp[k];
    end else if (off == 32'hBFF8) begin
      if (a_we) m_mtime = merge_bytes(m_mtime, a_wd, a_be);
      else      rd = m_mtime;
    end else begin
      e = 1'b1;
    end
  endfunction

  // Single request with response check one cycle later.
  task automatic bus(input logic a_we, input logic [AW-1:0] a_addr, input logic [63:0] a_wd,
                     input logic [7:0] a_be, input string tag);
    logic [63:0] exp_rd;
    logic        exp_err;
    @(negedge clk);
    req = 1'b1; we = a_we; addr = a_addr; wdata = a_wd; be = a_be;
    model_access(a_we, a_addr, a_wd, a_be, exp_rd, exp_err);
    @(posedge clk); #1;
    req = 1'b0;
    check({tag, ".rvalid"}, 64'(rvalid), 64'd1);
    check({tag, ".rdata"},  rdata, exp_rd);
    check({tag, ".err"},    64'(err), 64'(exp_err));
  endtask

  task automatic rtc_tick();
    @(negedge clk); rtc = 1'b1;
    repeat (3) @(negedge clk);
    rtc = 1'b0;
    repeat (3) @(negedge clk);
    m_mtime = m_mtime + 64'd1;
  endtask

  initial begin
    logic [63:0]   w;
    logic [63:0]   exp_rd;
    logic          exp_err;
    logic [NH-1:0] exp_irq;
    logic [AW-1:0] a;
    logic          lwe;
    logic [7:0]    lbe;

    rst_n = 1'b0; rtc = 1'b0; req = 1'b0; we = 1'b0;
    addr = '0; wdata = '0; be = '0;
    model_reset();
    #1;
    check("rst.rvalid", 64'(rvalid), 64'd0);
    check("rst.rdata", rdata, 64'd0);
    check("rst.err", 64'(err), 64'd0);
    check("rst.irq", 64'(timer_irq), 64'd0);
    check("rst.ipi", 64'(ipi), 64'd0);
    check("gnt", 64'(gnt), 64'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset contents.
    bus(1'b0, 20'hBFF8, 64'd0, 8'h00, "rd_mtime0");
    bus(1'b0, 20'h4000, 64'd0, 8'h00, "rd_cmp0");
    check("irq_after_reset", 64'(timer_irq), 64'd0);

    // Five RTC ticks.
    repeat (5) rtc_tick();
    bus(1'b0, 20'hBFF8, 64'd0, 8'h00, "rd_mtime5");

    // Timer interrupt rises one cycle after mtime reaches 7.
    bus(1'b1, 20'h4000, 64'd7, 8'hFF, "wr_cmp7");
    rtc_tick();
    check("irq_at6", 64'(timer_irq), 64'd0);
    @(negedge clk); rtc = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #1;
    check("irq_at_mtime7", 64'(timer_irq), 64'd0);
    @(posedge clk); #1;
    check("irq_after_mtime7", 64'(timer_irq), 64'b01);
    rtc = 1'b0;
    repeat (3) @(negedge clk);
    m_mtime = m_mtime + 64'd1;
    bus(1'b0, 20'hBFF8, 64'd0, 8'h00, "rd_mtime7");

    // Wrap-around.
    bus(1'b1, 20'hBFF8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, "wr_mtime_max");
    rtc_tick();
    bus(1'b0, 20'hBFF8, 64'd0, 8'h00, "rd_mtime_wrap");

    // Partial write coinciding with a tick: carry shows in the upper bytes.
    bus(1'b1, 20'hBFF8, 64'h1234_5678_FFFF_FFFF, 8'hFF, "wr_mtime_pre");
    w = {$urandom, $urandom};
    @(negedge clk); rtc = 1'b1;
    @(negedge clk);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 20'hBFF8; wdata = w; be = 8'h0F;
    @(posedge clk); #1;
    req = 1'b0;
    check("tickwr.rvalid", 64'(rvalid), 64'd1);
    check("tickwr.rdata", rdata, 64'd0);
    m_mtime = merge_bytes(m_mtime + 64'd1, w, 8'h0F);
    rtc = 1'b0;
    repeat (3) @(negedge clk);
    bus(1'b0, 20'hBFF8, 64'd0, 8'h00, "rd_mtime_tickwr");

    // Software interrupts.
    bus(1'b1, 20'h0000, 64'h1_0000_0000, 8'hFF, "wr_msip_hi");
    check("ipi_10", 64'(ipi), 64'b10);
    bus(1'b1, 20'h0000, 64'd1, 8'h01, "wr_msip_lo");
    check("ipi_11", 64'(ipi), 64'b11);
    bus(1'b0, 20'h0000, 64'd0, 8'h00, "rd_msip");

    // Unmapped offsets.
    bus(1'b0, 20'h4010, 64'd0, 8'h00, "rd_unmapped");
    bus(1'b1, 20'h8000, {$urandom, $urandom}, 8'hFF, "wr_unmapped");
    bus(1'b1, 20'h0008, 64'h0, 8'hFF, "wr_msip_bad");
    bus(1'b0, 20'hBFF8, 64'd0, 8'h00, "rd_mtime_keep");
    bus(1'b0, 20'h4000, 64'd0, 8'h00, "rd_cmp0_keep");
    bus(1'b0, 20'h4008, 64'd0, 8'h00, "rd_cmp1_keep");
    bus(1'b0, 20'h0000, 64'd0, 8'h00, "rd_msip_keep");

    // Back-to-back randomized traffic.
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 8))
        0: a = 20'h0000;
        1: a = 20'h4000;
        2: a = 20'h4008;
        3: a = 20'hBFF8;
        4: a = 20'h4010;
        5: a = 20'h8000;
        6: a = 20'h0008;
        7: a = 20'h4000 | 20'($urandom_range(0, 7));
        default: a = 20'($urandom);
      endcase
      lwe = 1'($urandom_range(0, 1));
      lbe = 8'($urandom);
      w   = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) w = {32'd0, $urandom};
      exp_irq = model_irq();
      @(negedge clk);
      req = 1'b1; we = lwe; addr = a; wdata = w; be = lbe;
      model_access(lwe, a, w, lbe, exp_rd, exp_err);
      @(posedge clk); #1;
      check("b2b.rvalid", 64'(rvalid), 64'd1);
      check("b2b.rdata", rdata, exp_rd);
      check("b2b.err", 64'(err), 64'(exp_err));
      check("b2b.ipi", 64'(ipi), 64'(m_msip));
      check("b2b.irq", 64'(timer_irq), 64'(exp_irq));
    end
    @(negedge clk); req = 1'b0;
    @(posedge clk); #1;
    check("b2b.idle_rvalid", 64'(rvalid), 64'd0);

    // Reset during an outstanding read.
    bus(1'b1, 20'h4000, 64'd0, 8'hFF, "wr_cmp_zero");
    bus(1'b1, 20'h0000, 64'h1_0000_0001, 8'hFF, "wr_msip_both");
    bus(1'b0, 20'h4008, 64'd0, 8'h00, "rd_before_rst");
    check("pre_rst.irq0", 64'(timer_irq[0]), 64'd1);
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 20'hBFF8;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst.rvalid", 64'(rvalid), 64'd0);
    check("async_rst.rdata", rdata, 64'd0);
    check("async_rst.irq", 64'(timer_irq), 64'd0);
    check("async_rst.ipi", 64'(ipi), 64'd0);
    @(posedge clk); #1;
    check("rst_hold.rvalid", 64'(rvalid), 64'd0);
    @(negedge clk);
    req = 1'b0;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    check("post_rst.rvalid", 64'(rvalid), 64'd0);
    bus(1'b0, 20'hBFF8, 64'd0, 8'h00, "rd_mtime_post_rst");
    bus(1'b0, 20'h4000, 64'd0, 8'h00, "rd_cmp0_post_rst");
    bus(1'b0, 20'h0000, 64'd0, 8'h00, "rd_msip_post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cva6_wrapper_clint.md
# cva6_wrapper_clint

Core-local interruptor for the CVA6 wrapper SoC. It decodes the `CLINTBase` window (`0x0200_0000`, length `0xC0000`) on the peripheral register bus and holds `msip`, `mtimecmp` and `mtime`. It drives the machine timer and software interrupt lines into the CVA6 hart(s). `mtime` advances on synchronized rising edges of an external real-time-clock input.

## Interface
Parameters:
- `NrHarts`, 1: number of harts served; range 1..64.
- `AddrWidth`, 20: offset width within the CLINT window (covers `CLINTLength`).

Ports:
- `clk_i`  in  1: system clock; all state is on its rising edge.
- `rst_ni`  in  1: asynchronous, active-low reset.
- `rtc_i`  in  1: asynchronous real-time tick; must be slower than `clk_i`/4.
- `req_i`  in  1: bus request.
- `we_i`  in  1: 1 = write, 0 = read.
- `addr_i`  in  `AddrWidth`: byte offset within the window; `addr_i[2:0]` is ignored.
- `wdata_i`  in  64: write data.
- `be_i`  in  8: byte enables.
- `gnt_o`  out  1: grant; tied to 1, so every request is accepted the cycle it is asserted.
- `rvalid_o`  out  1: response valid, exactly one cycle after an accepted request.
- `rdata_o`  out  64: read data; 0 for writes and for errors.
- `err_o`  out  1: unmapped offset; qualified by `rvalid_o`.
- `timer_irq_o`  out  `NrHarts`: machine timer interrupt, one bit per hart.
- `ipi_o`  out  `NrHarts`: machine software interrupt, one bit per hart.

## Operation
Register map (8-byte aligned words):
- `0x0000 + 8k`: `msip`. Bits[0] and [32] hold `msip[2k]` and `msip[2k+1]`; all other bits read 0. A write updates `msip[2k]` iff `be_i[0]`, from `wdata_i[0]`, and `msip[2k+1]` iff `be_i[4]`, from `wdata_i[32]`.
- `0x4000 + 8h`: `mtimecmp[h]`, 64 bits, byte-enable writable.
- `0xBFF8`: `mtime`, 64 bits, byte-enable writable.
- Decoding is valid only for harts `< NrHarts`. Any other offset returns `err_o`=1 and `rdata_o`=0, and the write is dropped with no state change.

`mtime` behaviour:
- Increments by 1 on each detected RTC rising edge.
- Wraps from `2^64-1` to 0 with no flag.
- If a bus write to `mtime` and a tick occur in the same cycle, the write wins for the enabled bytes and the tick is lost. Unenabled bytes take the incremented value.

Interrupt outputs:
- `timer_irq_o[h]` is registered `(mtime >= mtimecmp[h])`, unsigned 64-bit compare, evaluated against the current register values each cycle.
- `ipi_o[h]` = `msip[h]` register output, with no extra delay.

Reset values: `mtime`=0, `mtimecmp[*]`=all ones, `msip`=0, `rvalid_o`=0, `rdata_o`=0, `err_o`=0, `timer_irq_o`=0, `ipi_o`=0, RTC synchronizer flops=0.

Reset mid-transaction: the pending response is discarded and no `rvalid_o` is issued.

## Timing
- Bus: request sampled at edge N; write takes effect at N; `rvalid_o`/`rdata_o`/`err_o` valid in cycle N+1.
- Read data reflects register contents before any write in that same cycle.
- Back-to-back requests every cycle are supported; the response stream matches request order one-to-one.
- RTC path: 2-flop synchronizer, then a previous-value flop. A tick is detected when `sync & ~prev`. `rtc_i` high sampled at edge E makes `mtime` increment at edge E+2 and `timer_irq_o` update at E+3.
- A write to `mtimecmp` at edge N updates `timer_irq_o` at N+1.
- A write to `msip` at edge N changes `ipi_o` immediately after N.

## Structure
- Add to `cva6_wrapper_pkg`: `ClintMsipOffset`=`0x0`, `ClintMtimecmpOffset`=`0x4000`, `ClintMtimeOffset`=`0xBFF8`, and `ClintMaxHarts`=64. The window comes from the existing `CLINTBase`/`CLINTLength`.
- Sub-module `cva6_wrapper_clint_rtc_sync`: synchronizer plus rising-edge detector; outputs a 1-cycle `tick` pulse.
- Top level contains the decode, register file, comparators and response register.

## Test plan
- Reset, then read `0xBFF8` and `0x4000` -> `rvalid_o` one cycle later with `rdata_o`=0 and `0xFFFF_FFFF_FFFF_FFFF`; `timer_irq_o`=0.
- Toggle `rtc_i` 5 times -> `mtime` reads 5. Write `mtimecmp[0]`=7 and give 2 more ticks -> `timer_irq_o[0]` rises exactly 1 cycle after `mtime` reaches 7.
- Write `mtime`=`0xFFFF_FFFF_FFFF_FFFF`, then one tick -> reads 0. Write `mtime` with `be_i`=`0x0F` in the same cycle as a tick: upper bytes incremented, lower bytes equal `wdata_i`.
- `NrHarts`=2: write `0x0000` with `wdata_i`=`0x1_0000_0000` and `be_i`=`0xFF` -> `ipi_o`=`2'b10`. Write with `be_i`=`0x01` and data 1 -> `ipi_o`=`2'b11`.
- Read `0x4010` with `NrHarts`=2, and write `0x8000` -> `err_o`=1, `rdata_o`=0, no register changes. Issue back-to-back mixed requests -> one response per request, in order.
- Assert `rst_ni` low during an outstanding read -> no `rvalid_o`, and all outputs return to their reset values asynchronously.
